sdram_cmd_decoder: RTL and testbench

//  Behavioural SDRAM device sitting directly downstream of the bus interface unit: decodes the
//  CS/RAS/CAS/WE command pins, tracks open row per bank, stores write data and returns read data

---
 rtl/sdram_cmd_decoder_pkg.sv | 37 +++
 rtl/sdram_cmd_decoder_bank_state.sv | 47 ++++
 rtl/sdram_cmd_decoder.sv | 98 +++++++++
 tb/tb_sdram_cmd_decoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_cmd_decoder_pkg.sv
// Shared definitions for the SDRAM pin-level model: command codes, size codes, bank states.
// Purely declarative; no latency or flow control of its own.
package sdram_cmd_decoder_pkg;

    // Command encodings as {RAS, CAS, WE} with CS low
    typedef enum logic [2:0] {
        CMD_BAD = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic {
        BANK_IDLE,
        BANK_ACTIVE
    } bank_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int PRE_ALL_BIT = 10;

    // Reserved size code behaves as a full word
    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_mask = 32'h0000_00FF;
            SIZE_HALF: size_mask = 32'h0000_FFFF;
            default:   size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/sdram_cmd_decoder_bank_state.sv
// Per-bank IDLE/ACTIVE tracker with latched open row and an illegal-access flag.
// State updates at the command edge; flag is combinational; no backpressure.
module sdram_cmd_decoder_bank_state
    import sdram_cmd_decoder_pkg::*;
#(
    parameter int ROW_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  cmd_e                cmd,
    input  logic                sel,
    input  logic                pre_all,
    input  logic [ROW_BITS-1:0] row,
    output logic                is_open,
    output logic [ROW_BITS-1:0] open_row,
    output logic                illegal
);

    bank_state_e state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BANK_IDLE;
            open_row <= '0;
        end else begin
            case (state)
                BANK_IDLE: begin
                    if (sel && cmd == CMD_ACT) begin
                        state    <= BANK_ACTIVE;
                        open_row <= row;
                    end
                end
                BANK_ACTIVE: begin
                    if (cmd == CMD_PRE && (sel || pre_all)) begin
                        state <= BANK_IDLE;
                    end
                end
                default: state <= BANK_IDLE;
            endcase
        end
    end

    assign is_open = (state == BANK_ACTIVE);
    assign illegal = sel && (((cmd == CMD_ACT) && is_open) ||
                             ((cmd == CMD_RD || cmd == CMD_WR) && !is_open));

endmodule

// File: rtl/sdram_cmd_decoder.sv
// Behavioural SDRAM endpoint: pin decode, per-bank row tracking, word array, read pipe.
// Read data appears CAS_LAT edges after the command edge; no backpressure, one READ per cycle.
module sdram_cmd_decoder
    import sdram_cmd_decoder_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int ROW_BITS  = 8,
    parameter int COL_BITS  = 8,
    parameter int CAS_LAT   = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 CS,
    input  logic                 RAS,
    input  logic                 CAS,
    input  logic                 WE,
    input  logic [1:0]           BS,
    input  logic [31:0]          Addr,
    input  logic [1:0]           Size,
    input  logic [31:0]          WData,
    output logic [31:0]          RData,
    output logic                 RDataValid,
    output logic [NUM_BANKS-1:0] BankOpen,
    output logic                 CmdErr
);

    localparam int IDX_BITS = 2 + ROW_BITS + COL_BITS;

    cmd_e                 cmd;
    logic [NUM_BANKS-1:0] bank_illegal;
    logic [ROW_BITS-1:0]  bank_row [NUM_BANKS];
    logic                 cmd_illegal;
    logic                 do_wr;
    logic                 do_rd;
    logic [IDX_BITS-1:0]  idx;
    logic [31:0]          mask;
    logic [31:0]          rd_word;
    logic                 unused_addr;

    logic [31:0]          mem [2**IDX_BITS];
    logic [CAS_LAT-1:0]   pipe_vld;
    logic [31:0]          pipe_dat [CAS_LAT];

    assign cmd = CS ? CMD_NOP : cmd_e'({RAS, CAS, WE});

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        sdram_cmd_decoder_bank_state #(.ROW_BITS(ROW_BITS)) u_bank (
            .clk      (Clk),
            .rst_n    (Rst),
            .cmd      (cmd),
            .sel      (BS == 2'(g)),
            .pre_all  (Addr[PRE_ALL_BIT]),
            .row      (Addr[ROW_BITS-1:0]),
            .is_open  (BankOpen[g]),
            .open_row (bank_row[g]),
            .illegal  (bank_illegal[g])
        );
    end

    // Illegal commands leave banks untouched: the bank FSM ignores them on its own
    assign cmd_illegal = (|bank_illegal) || (cmd == CMD_BAD) ||
                         ((cmd == CMD_REF) && (|BankOpen));

    assign do_wr       = (cmd == CMD_WR) && BankOpen[BS];
    assign do_rd       = (cmd == CMD_RD) && BankOpen[BS];
    assign idx         = {BS, bank_row[BS], Addr[COL_BITS-1:0]};
    assign mask        = size_mask(Size);
    assign rd_word     = mem[idx] & mask;
    assign unused_addr = ^Addr;

    // Array content survives reset
    always_ff @(posedge Clk) begin
        if (do_wr) begin
            mem[idx] <= (mem[idx] & ~mask) | (WData & mask);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pipe_vld   <= '0;
            for (int i = 0; i < CAS_LAT; i++) pipe_dat[i] <= '0;
            RData      <= '0;
            RDataValid <= 1'b0;
            CmdErr     <= 1'b0;
        end else begin
            pipe_vld[0] <= do_rd;
            pipe_dat[0] <= rd_word;
            for (int i = 1; i < CAS_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
            RDataValid <= pipe_vld[CAS_LAT-1];
            if (pipe_vld[CAS_LAT-1]) RData <= pipe_dat[CAS_LAT-1];
            CmdErr <= cmd_illegal;
        end
    end

endmodule

// File: tb/tb_sdram_cmd_decoder.sv
// Directed vector bench for sdram_cmd_decoder with hand-computed expectations.
module tb_sdram_cmd_decoder;

    localparam logic [2:0] P_ACT = 3'b011;
    localparam logic [2:0] P_RD  = 3'b101;
    localparam logic [2:0] P_WR  = 3'b100;
    localparam logic [2:0] P_PRE = 3'b010;
    localparam logic [2:0] P_REF = 3'b001;
    localparam logic [2:0] P_NOP = 3'b111;
    localparam logic [2:0] P_BAD = 3'b000;
    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] SZ_W  = 2'b10;
    localparam logic [1:0] SZ_R  = 2'b11;

    typedef struct {
        logic        cs;
        logic [2:0]  pins;
        logic [1:0]  bs;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  exp_open;
        logic        exp_err;
        logic        exp_vld;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        cs, ras, cas, we;
    logic [1:0]  bs;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [3:0]  bank_open;
    logic        cmd_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd;
    vec_t        vecs[$];

    sdram_cmd_decoder dut (
        .Clk        (clk),
        .Rst        (rst_n),
        .CS         (cs),
        .RAS        (ras),
        .CAS        (cas),
        .WE         (we),
        .BS         (bs),
        .Addr       (addr),
        .Size       (size),
        .WData      (wdata),
        .RData      (rdata),
        .RDataValid (rdata_valid),
        .BankOpen   (bank_open),
        .CmdErr     (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic c, input logic [2:0] p, input logic [1:0] b,
                                input logic [31:0] a, input logic [1:0] s, input logic [31:0] w,
                                input logic [3:0] o, input logic e, input logic v,
                                input logic [31:0] r);
        vec_t t;
        t.cs = c; t.pins = p; t.bs = b; t.addr = a; t.size = s; t.wdata = w;
        t.exp_open = o; t.exp_err = e; t.exp_vld = v; t.exp_rd = r;
        return t;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [2:0] p, input logic [1:0] b,
                         input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
        cs = c; {ras, cas, we} = p; bs = b; addr = a; size = s; wdata = w;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, P_NOP, 2'd0, 32'h0, SZ_W, 32'h0);
        last_rd = 32'h0;

        // row: cs pins bs addr size wdata | open err vld rdata
        vecs.push_back(mk(0, P_ACT, 1, 32'h12,  SZ_W, 32'h0,        4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_WR,  1, 32'h34,  SZ_W, 32'hDEADBEEF, 4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_RD,  1, 32'h34,  SZ_W, 32'h0,        4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(1, P_NOP, 0, 32'h0,   SZ_W, 32'h0,        4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_WR,  1, 32'h34,  SZ_B, 32'h123456AA, 4'b0010, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, P_RD,  1, 32'h34,  SZ_H, 32'h0,        4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_RD,  1, 32'h34,  SZ_W, 32'h0,        4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_NOP, 0, 32'h0,   SZ_W, 32'h0,        4'b0010, 0, 1, 32'h0000BEAA));
        vecs.push_back(mk(0, P_NOP, 0, 32'h0,   SZ_W, 32'h0,        4'b0010, 0, 1, 32'hDEADBEAA));
        vecs.push_back(mk(0, P_WR,  1, 32'h0,   SZ_W, 32'h11111111, 4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_WR,  1, 32'h1,   SZ_W, 32'h22222222, 4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_WR,  1, 32'h2,   SZ_W, 32'h33333333, 4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_RD,  1, 32'h0,   SZ_W, 32'h0,        4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_RD,  1, 32'h1,   SZ_B, 32'h0,        4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_RD,  1, 32'h2,   SZ_W, 32'h0,        4'b0010, 0, 1, 32'h11111111));
        vecs.push_back(mk(0, P_NOP, 0, 32'h0,   SZ_W, 32'h0,        4'b0010, 0, 1, 32'h00000022));
        vecs.push_back(mk(0, P_NOP, 0, 32'h0,   SZ_W, 32'h0,        4'b0010, 0, 1, 32'h33333333));
        vecs.push_back(mk(0, P_RD,  2, 32'h0,   SZ_W, 32'h0,        4'b0010, 1, 0, 32'h0));
        vecs.push_back(mk(0, P_ACT, 1, 32'h55,  SZ_W, 32'h0,        4'b0010, 1, 0, 32'h0));
        vecs.push_back(mk(0, P_RD,  1, 32'h34,  SZ_W, 32'h0,        4'b0010, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_BAD, 1, 32'h34,  SZ_W, 32'h0,        4'b0010, 1, 0, 32'h0));
        vecs.push_back(mk(0, P_REF, 0, 32'h0,   SZ_W, 32'h0,        4'b0010, 1, 1, 32'hDEADBEAA));
        vecs.push_back(mk(0, P_PRE, 1, 32'h0,   SZ_W, 32'h0,        4'b0000, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_REF, 0, 32'h0,   SZ_W, 32'h0,        4'b0000, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_RD,  1, 32'h34,  SZ_W, 32'h0,        4'b0000, 1, 0, 32'h0));
        vecs.push_back(mk(0, P_ACT, 0, 32'h01,  SZ_W, 32'h0,        4'b0001, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_ACT, 3, 32'h02,  SZ_W, 32'h0,        4'b1001, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_WR,  0, 32'h5,   SZ_W, 32'hA0A0A0A0, 4'b1001, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_WR,  3, 32'h5,   SZ_W, 32'hB3B3B3B3, 4'b1001, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_RD,  0, 32'h5,   SZ_W, 32'h0,        4'b1001, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_RD,  3, 32'h5,   SZ_W, 32'h0,        4'b1001, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_PRE, 0, 32'h400, SZ_W, 32'h0,        4'b0000, 0, 1, 32'hA0A0A0A0));
        vecs.push_back(mk(1, P_BAD, 0, 32'h0,   SZ_W, 32'h0,        4'b0000, 0, 1, 32'hB3B3B3B3));
        vecs.push_back(mk(0, P_PRE, 2, 32'h0,   SZ_W, 32'h0,        4'b0000, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_ACT, 0, 32'h101, SZ_W, 32'h0,        4'b0001, 0, 0, 32'h0));
        vecs.push_back(mk(0, P_RD,  0, 32'h5,   SZ_R, 32'h0,        4'b0001, 0, 0, 32'h0));
        vecs.push_back(mk(1, P_NOP, 0, 32'h0,   SZ_W, 32'h0,        4'b0001, 0, 0, 32'h0));
        vecs.push_back(mk(1, P_NOP, 0, 32'h0,   SZ_W, 32'h0,        4'b0001, 0, 1, 32'hA0A0A0A0));

        #3;
        check("reset_rdata", -1, rdata, 32'h0);
        check("reset_rvalid", -1, 32'(rdata_valid), 32'h0);
        check("reset_bankopen", -1, 32'(bank_open), 32'h0);
        check("reset_cmderr", -1, 32'(cmd_err), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cs, vecs[i].pins, vecs[i].bs, vecs[i].addr, vecs[i].size, vecs[i].wdata);
            @(posedge clk); #1;
            if (vecs[i].exp_vld) last_rd = vecs[i].exp_rd;
            check("bankopen", i, 32'(bank_open), 32'(vecs[i].exp_open));
            check("cmderr", i, 32'(cmd_err), 32'(vecs[i].exp_err));
            check("rvalid", i, 32'(rdata_valid), 32'(vecs[i].exp_vld));
            check("rdata", i, rdata, last_rd);
        end

        // Reset with a read in flight: pending data must be dropped
        drive(1'b0, P_RD, 2'd0, 32'h5, SZ_W, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, P_NOP, 2'd0, 32'h0, SZ_W, 32'h0);
        rst_n = 1'b0;
        #1;
        check("midreset_rdata", 100, rdata, 32'h0);
        check("midreset_rvalid", 100, 32'(rdata_valid), 32'h0);
        check("midreset_bankopen", 100, 32'(bank_open), 32'h0);
        check("midreset_cmderr", 100, 32'(cmd_err), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("postreset_rvalid", 101 + k, 32'(rdata_valid), 32'h0);
            check("postreset_bankopen", 101 + k, 32'(bank_open), 32'h0);
        end

        // Array survives reset: reopen row 0x01 in bank 0 and read back column 5
        drive(1'b0, P_ACT, 2'd0, 32'h01, SZ_W, 32'h0);
        @(posedge clk); #1;
        check("reopen_bankopen", 110, 32'(bank_open), 32'h1);
        drive(1'b0, P_RD, 2'd0, 32'h5, SZ_W, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, P_NOP, 2'd0, 32'h0, SZ_W, 32'h0);
        @(posedge clk); #1;
        check("reopen_rvalid_early", 111, 32'(rdata_valid), 32'h0);
        @(posedge clk); #1;
        check("reopen_rvalid", 112, 32'(rdata_valid), 32'h1);
        check("reopen_rdata", 112, rdata, 32'hA0A0A0A0);
        @(posedge clk); #1;
        check("reopen_rvalid_pulse", 113, 32'(rdata_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
